// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use hazard detection,
//               write-back bypass into the captured/held operands, flush and
//               EX back-pressure handling.
// Config      : define ID_EX_BUBBLE_CNT_EN to build the saturating load-use
//               bubble counter; otherwise bubble_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // decode stage
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic [3:0]       id_aluop,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic [31:0]      id_pc,
  // write-back port
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  // pipeline control
  input  logic             flush,
  input  logic             ex_stall,
  // EX-side register outputs
  output logic             id_ex_valid,
  output logic             id_ex_regwrite,
  output logic             id_ex_memread,
  output logic             id_ex_memwrite,
  output logic             id_ex_memtoreg,
  output logic             id_ex_alusrc,
  output logic [4:0]       id_ex_rs,
  output logic [4:0]       id_ex_rt,
  output logic [4:0]       id_ex_rd,
  output logic [3:0]       id_ex_aluop,
  output logic [31:0]      id_ex_rs_data,
  output logic [31:0]      id_ex_rt_data,
  output logic [31:0]      id_ex_imm,
  output logic [31:0]      id_ex_pc,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_cnt
);

  // All EX-side state in one packed record; an all-zero record is a bubble.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  aluop;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_reg_t;

  ex_reg_t r_ex;
  ex_reg_t w_capture;

  logic w_wb_live;
  logic w_byp_id_rs;
  logic w_byp_id_rt;
  logic w_byp_ex_rs;
  logic w_byp_ex_rt;
  logic w_ex_rd_live;
  logic w_load_use;

  // A write to $0 is architecturally discarded, so it never bypasses.
  assign w_wb_live   = wb_regwrite && (wb_rd != 5'd0);
  assign w_byp_id_rs = w_wb_live && (wb_rd == id_rs);
  assign w_byp_id_rt = w_wb_live && (wb_rd == id_rt);
  assign w_byp_ex_rs = w_wb_live && (wb_rd == r_ex.rs);
  assign w_byp_ex_rt = w_wb_live && (wb_rd == r_ex.rt);

  // Load in EX whose destination is read by the instruction in ID; a load
  // into $0 produces nothing to wait for.
  assign w_ex_rd_live = r_ex.valid && r_ex.memread && (r_ex.rd != 5'd0);
  assign w_load_use   = id_valid && w_ex_rd_live &&
                        ((r_ex.rd == id_rs) || (r_ex.rd == id_rt));

  // Upstream freezes when EX back-pressures, or when a bubble is being
  // inserted for a load-use hazard that a flush is not about to squash.
  assign stall_id = ex_stall || (w_load_use && !flush);

  // Record to load on a normal capture; an invalid decode slot becomes a bubble.
  always_comb begin
    w_capture = '0;
    if (id_valid) begin
      w_capture.valid    = 1'b1;
      w_capture.regwrite = id_regwrite;
      w_capture.memread  = id_memread;
      w_capture.memwrite = id_memwrite;
      w_capture.memtoreg = id_memtoreg;
      w_capture.alusrc   = id_alusrc;
      w_capture.rs       = id_rs;
      w_capture.rt       = id_rt;
      w_capture.rd       = id_rd;
      w_capture.aluop    = id_aluop;
      w_capture.rs_data  = w_byp_id_rs ? wb_data : id_rs_data;
      w_capture.rt_data  = w_byp_id_rt ? wb_data : id_rt_data;
      w_capture.imm      = id_imm;
      w_capture.pc       = id_pc;
    end
  end

  // Pipeline register: reset, flush, hold (with WB refresh), bubble, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= '0;
    end else if (flush) begin
      r_ex <= '0;
    end else if (ex_stall) begin
      // Held operands must not go stale while a writer retires underneath.
      if (w_byp_ex_rs) begin
        r_ex.rs_data <= wb_data;
      end
      if (w_byp_ex_rt) begin
        r_ex.rt_data <= wb_data;
      end
    end else if (w_load_use) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_capture;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic             w_bubble_ins;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Only a genuine load-use insertion counts; flush and hold edges do not.
  assign w_bubble_ins = !flush && !ex_stall && w_load_use;

  // Saturating count of inserted load-use bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble_ins && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  assign bubble_cnt = '0;
`endif

  assign id_ex_valid    = r_ex.valid;
  assign id_ex_regwrite = r_ex.regwrite;
  assign id_ex_memread  = r_ex.memread;
  assign id_ex_memwrite = r_ex.memwrite;
  assign id_ex_memtoreg = r_ex.memtoreg;
  assign id_ex_alusrc   = r_ex.alusrc;
  assign id_ex_rs       = r_ex.rs;
  assign id_ex_rt       = r_ex.rt;
  assign id_ex_rd       = r_ex.rd;
  assign id_ex_aluop    = r_ex.aluop;
  assign id_ex_rs_data  = r_ex.rs_data;
  assign id_ex_rt_data  = r_ex.rt_data;
  assign id_ex_imm      = r_ex.imm;
  assign id_ex_pc       = r_ex.pc;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed scenarios then
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [3:0] id_aluop;
  logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc;
  logic wb_regwrite;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic flush, ex_stall;
  logic id_ex_valid, id_ex_regwrite, id_ex_memread, id_ex_memwrite;
  logic id_ex_memtoreg, id_ex_alusrc;
  logic [4:0] id_ex_rs, id_ex_rt, id_ex_rd;
  logic [3:0] id_ex_aluop;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc;
  logic stall_id;
  logic [TB_CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_stall(ex_stall),
    .id_ex_valid(id_ex_valid), .id_ex_regwrite(id_ex_regwrite),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
    .id_ex_memtoreg(id_ex_memtoreg), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_aluop(id_ex_aluop), .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_pc(id_ex_pc), .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  // Reference model: the instruction the EX stage should currently hold.
  typedef struct {
    bit valid, regwrite, memread, memwrite, memtoreg, alusrc;
    int rs, rt, rd, aluop;
    bit [31:0] rs_data, rt_data, imm, pc;
  } instr_t;

  instr_t m;
  int     m_cnt;
  int     n_tests = 0;
  int     n_fail  = 0;

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic bit model_load_use();
    return id_valid && m.valid && m.memread && m.rd != 0 &&
           (m.rd == int'(id_rs) || m.rd == int'(id_rt));
  endfunction

  function automatic bit model_stall();
    return ex_stall || (model_load_use() && !flush);
  endfunction

  function automatic bit wb_writes(int r);
    return wb_regwrite && r != 0 && int'(wb_rd) == r;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit lu;
    lu = model_load_use();
    if (rst) begin
      m = bubble();
      m_cnt = 0;
    end else if (flush) begin
      m = bubble();
    end else if (ex_stall) begin
      if (wb_writes(m.rs)) m.rs_data = wb_data;
      if (wb_writes(m.rt)) m.rt_data = wb_data;
    end else if (lu) begin
      m = bubble();
`ifdef ID_EX_BUBBLE_CNT_EN
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
    end else if (!id_valid) begin
      m = bubble();
    end else begin
      m.valid = 1; m.regwrite = id_regwrite; m.memread = id_memread;
      m.memwrite = id_memwrite; m.memtoreg = id_memtoreg; m.alusrc = id_alusrc;
      m.rs = int'(id_rs); m.rt = int'(id_rt); m.rd = int'(id_rd);
      m.aluop = int'(id_aluop);
      m.rs_data = wb_writes(int'(id_rs)) ? wb_data : id_rs_data;
      m.rt_data = wb_writes(int'(id_rt)) ? wb_data : id_rt_data;
      m.imm = id_imm; m.pc = id_pc;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"},    32'(id_ex_valid),    32'(m.valid));
    chk({tag, ".regwrite"}, 32'(id_ex_regwrite), 32'(m.regwrite));
    chk({tag, ".memread"},  32'(id_ex_memread),  32'(m.memread));
    chk({tag, ".memwrite"}, 32'(id_ex_memwrite), 32'(m.memwrite));
    chk({tag, ".memtoreg"}, 32'(id_ex_memtoreg), 32'(m.memtoreg));
    chk({tag, ".alusrc"},   32'(id_ex_alusrc),   32'(m.alusrc));
    chk({tag, ".rs"},       32'(id_ex_rs),       32'(m.rs));
    chk({tag, ".rt"},       32'(id_ex_rt),       32'(m.rt));
    chk({tag, ".rd"},       32'(id_ex_rd),       32'(m.rd));
    chk({tag, ".aluop"},    32'(id_ex_aluop),    32'(m.aluop));
    chk({tag, ".rs_data"},  id_ex_rs_data,       m.rs_data);
    chk({tag, ".rt_data"},  id_ex_rt_data,       m.rt_data);
    chk({tag, ".imm"},      id_ex_imm,           m.imm);
    chk({tag, ".pc"},       id_ex_pc,            m.pc);
    chk({tag, ".cnt"},      32'(bubble_cnt),     32'(m_cnt));
  endtask

  // Inputs are set just after an edge; check stall mid-cycle, then the edge.
  task automatic step(string tag);
    #4;
    chk({tag, ".stall_id"}, 32'(stall_id), 32'(model_stall()));
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rst = 0; flush = 0; ex_stall = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    id_alusrc = 0; id_aluop = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_pc = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic put_lw(int rd, int base);
    id_valid = 1; id_rs = 5'(base); id_rt = 5'(rd); id_rd = 5'(rd);
    id_regwrite = 1; id_memread = 1; id_memtoreg = 1; id_alusrc = 1;
    id_aluop = 4'h2; id_rs_data = 32'h1000; id_rt_data = 32'h0;
    id_imm = 32'h4; id_pc = 32'h100;
  endtask

  task automatic put_alu(int rs, int rt, int rd);
    id_valid = 1; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_regwrite = 1; id_memread = 0; id_memtoreg = 0; id_alusrc = 0;
    id_aluop = 4'h3; id_rs_data = 32'h1111; id_rt_data = 32'h2222;
    id_imm = 32'hFFFF_FFF0; id_pc = 32'h104;
  endtask

  int exp_cnt_after;

  initial begin
    idle();
    rst = 1;
    m = bubble(); m_cnt = 0;
    @(posedge clk); #1;
    step("reset");
    chk("reset.stall_const", 32'(stall_id), 32'd0);

    // load-use on $5: one bubble then the add is captured
    rst = 0;
    put_lw(5, 1);              step("lu.lw");
    put_alu(5, 7, 6);
    #4; chk("lu.stall_hi", 32'(stall_id), 32'd1); #0;
    @(posedge clk); model_edge(); #1; check_all("lu.bubble");
    chk("lu.bubble_valid", 32'(id_ex_valid), 32'd0);
    step("lu.capture");
    chk("lu.capture_rd", 32'(id_ex_rd), 32'd6);
`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt_after = 1;
`else
    exp_cnt_after = 0;
`endif
    chk("lu.cnt_const", 32'(bubble_cnt), 32'(exp_cnt_after));

    // load into $0 never stalls
    idle(); put_lw(0, 1);      step("zero.lw");
    put_alu(0, 0, 8);          step("zero.use");
    chk("zero.valid_const", 32'(id_ex_valid), 32'd1);
    chk("zero.cnt_const", 32'(bubble_cnt), 32'(exp_cnt_after));

    // WB bypass on capture
    idle(); put_alu(3, 4, 9); id_rs_data = 32'h11;
    wb_regwrite = 1; wb_rd = 3; wb_data = 32'hAB;
    step("byp.cap");
    chk("byp.rs_data_const", id_ex_rs_data, 32'hAB);

    // two-cycle hold with WB refreshing the held rt operand
    idle(); ex_stall = 1; put_alu(10, 11, 12);
    wb_regwrite = 1; wb_rd = 4; wb_data = 32'h55;
    step("hold.c1");
    wb_regwrite = 0;
    step("hold.c2");
    chk("hold.rt_data_const", id_ex_rt_data, 32'h55);
    chk("hold.rs_const", 32'(id_ex_rs), 32'd3);

    // flush beats ex_stall and load_use
    idle(); put_lw(9, 1);      step("fl.lw");
    put_alu(9, 2, 13); flush = 1; ex_stall = 1;
    step("fl.edge");
    chk("fl.valid_const", 32'(id_ex_valid), 32'd0);
    chk("fl.cnt_const", 32'(bubble_cnt), 32'(exp_cnt_after));

    // reset during a load-use stall
    idle(); put_lw(7, 1);      step("rst.lw");
    put_alu(7, 7, 14); rst = 1;
    step("rst.edge");
    chk("rst.cnt_const", 32'(bubble_cnt), 32'd0);

    // saturation: more load-use events than the counter can hold
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      idle(); put_lw(2, 1);    step("sat.lw");
      put_alu(2, 0, 3);        step("sat.bubble");
                               step("sat.capture");
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("sat.cnt_const", 32'(bubble_cnt), 32'(CNT_MAX));
`else
    chk("sat.cnt_const", 32'(bubble_cnt), 32'd0);
`endif

    // randomized traffic, small register space to provoke hazards
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      ex_stall    = ($urandom_range(0, 4) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 3));
      id_regwrite = 1'($urandom);
      id_memread  = 1'($urandom);
      id_memwrite = 1'($urandom);
      id_memtoreg = 1'($urandom);
      id_alusrc   = 1'($urandom);
      id_aluop    = 4'($urandom);
      id_rs_data  = $urandom;
      id_rt_data  = $urandom;
      id_imm      = $urandom;
      id_pc       = $urandom;
      wb_regwrite = 1'($urandom);
      wb_rd       = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
